// File: rtl/draw_pkg.sv
`default_nettype none
// ============================================================================
// Module   : draw_pkg
// Brief    : Shared select codes, sprite geometry, colours and state encoding.
// Revision : 1.0
// ============================================================================
package draw_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    localparam int PLAYER_W = 8;
    localparam int PLAYER_H = 8;
    localparam int ENEMY_W  = 8;
    localparam int ENEMY_H  = 6;
    localparam int BULLET_W = 1;
    localparam int BULLET_H = 3;

    localparam logic [2:0] PLAYER_COL = 3'b010;
    localparam logic [2:0] ENEMY_COL  = 3'b100;
    localparam logic [2:0] BULLET_COL = 3'b111;
    localparam logic [2:0] ERASE_COL  = 3'b000;

    localparam logic [3:0] SEL_NONE   = 4'd0;
    localparam logic [3:0] SEL_PLAYER = 4'd1;
    localparam logic [3:0] SEL_ENEMY1 = 4'd2;
    localparam logic [3:0] SEL_ENEMY2 = 4'd3;
    localparam logic [3:0] SEL_ENEMY3 = 4'd4;
    localparam logic [3:0] SEL_ENEMY4 = 4'd5;
    localparam logic [3:0] SEL_BULLET = 4'd6;

    typedef struct packed {
        logic [7:0] base_x;
        logic [6:0] base_y;
        logic [7:0] w;
        logic [6:0] h;
        logic [2:0] colour;
    } sprite_attr_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READY  = 3'd1,
        ST_SCAN   = 3'd2,
        ST_FINISH = 3'd3,
        ST_HOLD   = 3'd4
    } draw_state_t;

endpackage
`default_nettype wire

// File: rtl/sprite_attr_mux.sv
`default_nettype none
// ============================================================================
// Module   : sprite_attr_mux
// Brief    : Selects origin, box size and colour of the object being drawn.
// Revision : 1.0
// ============================================================================
module sprite_attr_mux
    import draw_pkg::*;
#(
    parameter int         PLAYER_W   = draw_pkg::PLAYER_W,
    parameter int         PLAYER_H   = draw_pkg::PLAYER_H,
    parameter int         ENEMY_W    = draw_pkg::ENEMY_W,
    parameter int         ENEMY_H    = draw_pkg::ENEMY_H,
    parameter int         BULLET_W   = draw_pkg::BULLET_W,
    parameter int         BULLET_H   = draw_pkg::BULLET_H,
    parameter logic [2:0] PLAYER_COL = draw_pkg::PLAYER_COL,
    parameter logic [2:0] ENEMY_COL  = draw_pkg::ENEMY_COL,
    parameter logic [2:0] BULLET_COL = draw_pkg::BULLET_COL,
    parameter logic [2:0] ERASE_COL  = draw_pkg::ERASE_COL
) (
    input  logic [3:0]   i_draw_select,
    input  logic [7:0]   i_player_x,
    input  logic [6:0]   i_player_y,
    input  logic [7:0]   i_enemy1_x,
    input  logic [6:0]   i_enemy1_y,
    input  logic [7:0]   i_enemy2_x,
    input  logic [6:0]   i_enemy2_y,
    input  logic [7:0]   i_enemy3_x,
    input  logic [6:0]   i_enemy3_y,
    input  logic [7:0]   i_enemy4_x,
    input  logic [6:0]   i_enemy4_y,
    input  logic [7:0]   i_bullet_x,
    input  logic [6:0]   i_bullet_y,
    input  logic [3:0]   i_enemy_alive,
    input  logic         i_bullet_active,
    output sprite_attr_t o_attr
);

    logic [7:0] w_enemy_x [4];
    logic [6:0] w_enemy_y [4];
    logic [3:0] w_enemy_off;
    logic [1:0] w_enemy_idx;

    assign w_enemy_x[0] = i_enemy1_x;
    assign w_enemy_x[1] = i_enemy2_x;
    assign w_enemy_x[2] = i_enemy3_x;
    assign w_enemy_x[3] = i_enemy4_x;
    assign w_enemy_y[0] = i_enemy1_y;
    assign w_enemy_y[1] = i_enemy2_y;
    assign w_enemy_y[2] = i_enemy3_y;
    assign w_enemy_y[3] = i_enemy4_y;

    assign w_enemy_off = i_draw_select - SEL_ENEMY1;
    assign w_enemy_idx = w_enemy_off[1:0];

    // Unknown select codes fall through to an all-zero (0x0) box.
    always_comb begin
        o_attr = '0;
        case (i_draw_select)
            SEL_PLAYER: begin
                o_attr.base_x = i_player_x;
                o_attr.base_y = i_player_y;
                o_attr.w      = 8'(PLAYER_W);
                o_attr.h      = 7'(PLAYER_H);
                o_attr.colour = PLAYER_COL;
            end
            SEL_ENEMY1, SEL_ENEMY2, SEL_ENEMY3, SEL_ENEMY4: begin
                o_attr.base_x = w_enemy_x[w_enemy_idx];
                o_attr.base_y = w_enemy_y[w_enemy_idx];
                o_attr.w      = 8'(ENEMY_W);
                o_attr.h      = 7'(ENEMY_H);
                o_attr.colour = i_enemy_alive[w_enemy_idx] ? ENEMY_COL : ERASE_COL;
            end
            SEL_BULLET: begin
                o_attr.base_x = i_bullet_x;
                o_attr.base_y = i_bullet_y;
                o_attr.w      = 8'(BULLET_W);
                o_attr.h      = 7'(BULLET_H);
                o_attr.colour = i_bullet_active ? BULLET_COL : ERASE_COL;
            end
            default: o_attr = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/draw_display_handler.sv
`default_nettype none
// ============================================================================
// Module   : draw_display_handler
// Brief    : Rasterises the selected object's bounding box into VGA pixels.
// Revision : 1.0
// ============================================================================
module draw_display_handler
    import draw_pkg::*;
#(
    parameter int         SCREEN_W   = draw_pkg::SCREEN_W,
    parameter int         SCREEN_H   = draw_pkg::SCREEN_H,
    parameter int         PLAYER_W   = draw_pkg::PLAYER_W,
    parameter int         PLAYER_H   = draw_pkg::PLAYER_H,
    parameter int         ENEMY_W    = draw_pkg::ENEMY_W,
    parameter int         ENEMY_H    = draw_pkg::ENEMY_H,
    parameter int         BULLET_W   = draw_pkg::BULLET_W,
    parameter int         BULLET_H   = draw_pkg::BULLET_H,
    parameter logic [2:0] PLAYER_COL = draw_pkg::PLAYER_COL,
    parameter logic [2:0] ENEMY_COL  = draw_pkg::ENEMY_COL,
    parameter logic [2:0] BULLET_COL = draw_pkg::BULLET_COL,
    parameter logic [2:0] ERASE_COL  = draw_pkg::ERASE_COL
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] draw_select,
    input  logic       enable_load,
    input  logic       enable_draw,
    input  logic [7:0] player_x,
    input  logic [6:0] player_y,
    input  logic [7:0] enemy1_x,
    input  logic [6:0] enemy1_y,
    input  logic [7:0] enemy2_x,
    input  logic [6:0] enemy2_y,
    input  logic [7:0] enemy3_x,
    input  logic [6:0] enemy3_y,
    input  logic [7:0] enemy4_x,
    input  logic [6:0] enemy4_y,
    input  logic [7:0] bullet_x,
    input  logic [6:0] bullet_y,
    input  logic [3:0] enemy_alive,
    input  logic       bullet_active,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       done
);

    sprite_attr_t w_sel_attr;

    sprite_attr_mux #(
        .PLAYER_W   (PLAYER_W),
        .PLAYER_H   (PLAYER_H),
        .ENEMY_W    (ENEMY_W),
        .ENEMY_H    (ENEMY_H),
        .BULLET_W   (BULLET_W),
        .BULLET_H   (BULLET_H),
        .PLAYER_COL (PLAYER_COL),
        .ENEMY_COL  (ENEMY_COL),
        .BULLET_COL (BULLET_COL),
        .ERASE_COL  (ERASE_COL)
    ) u_attr_mux (
        .i_draw_select   (draw_select),
        .i_player_x      (player_x),
        .i_player_y      (player_y),
        .i_enemy1_x      (enemy1_x),
        .i_enemy1_y      (enemy1_y),
        .i_enemy2_x      (enemy2_x),
        .i_enemy2_y      (enemy2_y),
        .i_enemy3_x      (enemy3_x),
        .i_enemy3_y      (enemy3_y),
        .i_enemy4_x      (enemy4_x),
        .i_enemy4_y      (enemy4_y),
        .i_bullet_x      (bullet_x),
        .i_bullet_y      (bullet_y),
        .i_enemy_alive   (enemy_alive),
        .i_bullet_active (bullet_active),
        .o_attr          (w_sel_attr)
    );

    draw_state_t  r_state_q,  w_state_d;
    sprite_attr_t r_attr_q,   w_attr_d;
    logic [7:0]   r_cx_q,     w_cx_d;
    logic [6:0]   r_cy_q,     w_cy_d;
    logic [7:0]   r_x_q,      w_x_d;
    logic [6:0]   r_y_q,      w_y_d;
    logic [2:0]   r_colour_q, w_colour_d;
    logic         r_plot_q,   w_plot_d;
    logic         r_done_q,   w_done_d;

    logic         w_row_end;
    logic         w_last;
    logic [7:0]   w_next_cx;
    logic [6:0]   w_next_cy;
    logic [7:0]   w_pix_cx;
    logic [6:0]   w_pix_cy;
    logic [8:0]   w_sum_x;
    logic [7:0]   w_sum_y;
    logic         w_on_screen;

    assign w_row_end = (r_cx_q == r_attr_q.w - 8'd1);
    assign w_last    = w_row_end && (r_cy_q == r_attr_q.h - 7'd1);
    assign w_next_cx = w_row_end ? 8'd0 : r_cx_q + 8'd1;
    assign w_next_cy = w_row_end ? r_cy_q + 7'd1 : r_cy_q;

    // READY emits the origin pixel; SCAN emits the pixel after the current one.
    assign w_pix_cx    = (r_state_q == ST_SCAN) ? w_next_cx : 8'd0;
    assign w_pix_cy    = (r_state_q == ST_SCAN) ? w_next_cy : 7'd0;
    assign w_sum_x     = {1'b0, r_attr_q.base_x} + {1'b0, w_pix_cx};
    assign w_sum_y     = {1'b0, r_attr_q.base_y} + {1'b0, w_pix_cy};
    assign w_on_screen = (w_sum_x < 9'(SCREEN_W)) && (w_sum_y < 8'(SCREEN_H));

    always_comb begin
        w_state_d  = r_state_q;
        w_attr_d   = r_attr_q;
        w_cx_d     = r_cx_q;
        w_cy_d     = r_cy_q;
        w_x_d      = r_x_q;
        w_y_d      = r_y_q;
        w_colour_d = r_colour_q;
        w_plot_d   = 1'b0;
        w_done_d   = 1'b0;

        case (r_state_q)
            ST_READY: begin
                if (enable_draw) begin
                    if ((r_attr_q.w == 8'd0) || (r_attr_q.h == 7'd0)) begin
                        w_state_d = ST_FINISH;
                        w_done_d  = 1'b1;
                    end else begin
                        w_state_d  = ST_SCAN;
                        w_cx_d     = 8'd0;
                        w_cy_d     = 7'd0;
                        w_x_d      = w_sum_x[7:0];
                        w_y_d      = w_sum_y[6:0];
                        w_colour_d = r_attr_q.colour;
                        w_plot_d   = w_on_screen;
                    end
                end
            end
            ST_SCAN: begin
                if (enable_draw) begin
                    if (w_last) begin
                        w_state_d = ST_FINISH;
                        w_done_d  = 1'b1;
                    end else begin
                        w_cx_d     = w_next_cx;
                        w_cy_d     = w_next_cy;
                        w_x_d      = w_sum_x[7:0];
                        w_y_d      = w_sum_y[6:0];
                        w_colour_d = r_attr_q.colour;
                        w_plot_d   = w_on_screen;
                    end
                end
            end
            ST_FINISH: w_state_d = ST_HOLD;
            default:   w_state_d = r_state_q;
        endcase

        // A load aborts whatever is in flight and re-arms from the new object.
        if (enable_load) begin
            w_state_d = ST_READY;
            w_attr_d  = w_sel_attr;
            w_cx_d    = 8'd0;
            w_cy_d    = 7'd0;
            w_plot_d  = 1'b0;
            w_done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state_q  <= ST_IDLE;
            r_attr_q   <= '0;
            r_cx_q     <= 8'd0;
            r_cy_q     <= 7'd0;
            r_x_q      <= 8'd0;
            r_y_q      <= 7'd0;
            r_colour_q <= 3'd0;
            r_plot_q   <= 1'b0;
            r_done_q   <= 1'b0;
        end else begin
            r_state_q  <= w_state_d;
            r_attr_q   <= w_attr_d;
            r_cx_q     <= w_cx_d;
            r_cy_q     <= w_cy_d;
            r_x_q      <= w_x_d;
            r_y_q      <= w_y_d;
            r_colour_q <= w_colour_d;
            r_plot_q   <= w_plot_d;
            r_done_q   <= w_done_d;
        end
    end

    assign x      = r_x_q;
    assign y      = r_y_q;
    assign colour = r_colour_q;
    assign plot   = r_plot_q;
    assign done   = r_done_q;

endmodule
`default_nettype wire

// File: tb/tb_draw_display_handler.sv
`default_nettype none
// ============================================================================
// Module   : tb_draw_display_handler
// Brief    : Directed and randomized checks against a pixel-list reference.
// Revision : 1.0
// ============================================================================
module tb_draw_display_handler;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] draw_select;
    logic       enable_load, enable_draw;
    logic [7:0] player_x, bullet_x;
    logic [6:0] player_y, bullet_y;
    logic [7:0] ex [4];
    logic [6:0] ey [4];
    logic [3:0] enemy_alive;
    logic       bullet_active;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot, done;

    always #5 clk = ~clk;

    draw_display_handler dut (
        .clk(clk), .reset(reset), .draw_select(draw_select),
        .enable_load(enable_load), .enable_draw(enable_draw),
        .player_x(player_x), .player_y(player_y),
        .enemy1_x(ex[0]), .enemy1_y(ey[0]), .enemy2_x(ex[1]), .enemy2_y(ey[1]),
        .enemy3_x(ex[2]), .enemy3_y(ey[2]), .enemy4_x(ex[3]), .enemy4_y(ey[3]),
        .bullet_x(bullet_x), .bullet_y(bullet_y),
        .enemy_alive(enemy_alive), .bullet_active(bullet_active),
        .x(x), .y(y), .colour(colour), .plot(plot), .done(done)
    );

    typedef struct packed {
        logic [7:0] px;
        logic [6:0] py;
        logic [2:0] pc;
        logic       pp;
    } pix_t;

    int   checks = 0;
    int   errors = 0;
    pix_t exp_q[$];
    pix_t exp_pix;
    bit   armed, emitted, exp_plot, exp_done;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: at load, list every pixel of the box in row-major order.
    function automatic void build_list();
        int bx, by, bw, bh, sx, sy;
        logic [2:0] c;
        pix_t p;
        bx = 0; by = 0; bw = 0; bh = 0; c = 3'd0;
        if (draw_select == 4'd1) begin
            bx = player_x; by = player_y; bw = 8; bh = 8; c = 3'b010;
        end else if (draw_select >= 4'd2 && draw_select <= 4'd5) begin
            bx = ex[draw_select - 4'd2]; by = ey[draw_select - 4'd2]; bw = 8; bh = 6;
            c = enemy_alive[draw_select - 4'd2] ? 3'b100 : 3'b000;
        end else if (draw_select == 4'd6) begin
            bx = bullet_x; by = bullet_y; bw = 1; bh = 3;
            c = bullet_active ? 3'b111 : 3'b000;
        end
        exp_q.delete();
        for (int r = 0; r < bh; r++) begin
            for (int k = 0; k < bw; k++) begin
                sx = bx + k;
                sy = by + r;
                p.px = sx[7:0];
                p.py = sy[6:0];
                p.pc = c;
                p.pp = (sx < 160) && (sy < 120);
                exp_q.push_back(p);
            end
        end
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_q.delete();
            armed = 0; emitted = 0; exp_plot = 0; exp_done = 0; exp_pix = '0;
        end else begin
            emitted = 0; exp_plot = 0; exp_done = 0;
            if (enable_load) begin
                build_list();
                armed = 1;
            end else if (armed && enable_draw) begin
                if (exp_q.size() > 0) begin
                    exp_pix  = exp_q.pop_front();
                    exp_plot = exp_pix.pp;
                    emitted  = 1;
                end else begin
                    exp_done = 1;
                    armed    = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("plot", plot, exp_plot);
            chk("done", done, exp_done);
            if (emitted) begin
                chk("x", x, exp_pix.px);
                chk("y", y, exp_pix.py);
                chk("colour", colour, exp_pix.pc);
            end
        end
    end

    task automatic load(input logic [3:0] sel, input logic draw);
        @(negedge clk);
        draw_select = sel; enable_load = 1'b1; enable_draw = draw;
        @(negedge clk);
        enable_load = 1'b0; enable_draw = 1'b1;
    endtask

    // Counts cycles after the first enabled edge; a paused window drops draw for 3 edges.
    task automatic scan(input int pause_at, input int limit, output int nplot,
                        output int done_cyc, output int fx, output int fy, output int fc,
                        output int lx, output int ly);
        nplot = 0; done_cyc = -1; fx = -1; fy = -1; fc = -1; lx = -1; ly = -1;
        for (int k = 1; k <= limit; k++) begin
            @(negedge clk);
            if (plot) begin
                if (nplot == 0) begin fx = x; fy = y; fc = colour; end
                lx = x; ly = y;
                nplot++;
            end
            if (done) begin
                done_cyc = k;
                break;
            end
            enable_draw = !(k >= pause_at && k < pause_at + 3);
        end
        enable_draw = 1'b0;
    endtask

    int np, dc, fx, fy, fc, lx, ly, ndone;

    initial begin
        reset = 1'b1; draw_select = 4'd0; enable_load = 1'b0; enable_draw = 1'b0;
        player_x = 8'd0; player_y = 7'd0; bullet_x = 8'd0; bullet_y = 7'd0;
        for (int i = 0; i < 4; i++) begin ex[i] = 8'd0; ey[i] = 7'd0; end
        enemy_alive = 4'hF; bullet_active = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_x", x, 0); chk("rst_y", y, 0); chk("rst_colour", colour, 0);
        chk("rst_plot", plot, 0); chk("rst_done", done, 0);
        reset = 1'b0;

        player_x = 8'd10; player_y = 7'd20;
        load(4'd1, 1'b0);
        scan(1000, 200, np, dc, fx, fy, fc, lx, ly);
        chk("player_plots", np, 64); chk("player_done", dc, 65);
        chk("player_x0", fx, 10); chk("player_y0", fy, 20); chk("player_col", fc, 2);
        chk("player_xl", lx, 17); chk("player_yl", ly, 27);

        bullet_x = 8'd50; bullet_y = 7'd100; bullet_active = 1'b1;
        load(4'd6, 1'b0);
        scan(1000, 50, np, dc, fx, fy, fc, lx, ly);
        chk("bullet_plots", np, 3); chk("bullet_done", dc, 4);
        chk("bullet_y0", fy, 100); chk("bullet_yl", ly, 102); chk("bullet_col", fc, 7);

        ex[1] = 8'd30; ey[1] = 7'd40; enemy_alive = 4'b1101;
        load(4'd3, 1'b0);
        scan(1000, 100, np, dc, fx, fy, fc, lx, ly);
        chk("erase_plots", np, 48); chk("erase_done", dc, 49); chk("erase_col", fc, 0);

        player_x = 8'd156; player_y = 7'd118;
        load(4'd1, 1'b0);
        scan(1000, 200, np, dc, fx, fy, fc, lx, ly);
        chk("edge_plots", np, 8); chk("edge_done", dc, 65);

        player_x = 8'd10; player_y = 7'd20;
        load(4'd1, 1'b0);
        scan(10, 200, np, dc, fx, fy, fc, lx, ly);
        chk("pause_plots", np, 64); chk("pause_done", dc, 68);

        load(4'd1, 1'b0);
        scan(1000, 20, np, dc, fx, fy, fc, lx, ly);
        chk("abort_no_done", dc, -1);
        load(4'd1, 1'b1);
        scan(1000, 200, np, dc, fx, fy, fc, lx, ly);
        chk("restart_plots", np, 64); chk("restart_done", dc, 65);
        chk("restart_x0", fx, 10);

        load(4'd0, 1'b0);
        scan(1000, 20, np, dc, fx, fy, fc, lx, ly);
        chk("none_done", dc, 1); chk("none_plots", np, 0);

        load(4'd1, 1'b0);
        scan(1000, 10, np, dc, fx, fy, fc, lx, ly);
        enable_draw = 1'b1;
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async_plot", plot, 0); chk("async_done", done, 0); chk("async_x", x, 0);
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        repeat (5) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("post_reset_done", ndone, 0);
        enable_draw = 1'b0;

        for (int it = 0; it < 40; it++) begin
            player_x = 8'($urandom_range(0, 255)); player_y = 7'($urandom_range(0, 127));
            bullet_x = 8'($urandom_range(0, 255)); bullet_y = 7'($urandom_range(0, 127));
            for (int i = 0; i < 4; i++) begin
                ex[i] = 8'($urandom_range(0, 255)); ey[i] = 7'($urandom_range(0, 127));
            end
            enemy_alive   = 4'($urandom_range(0, 15));
            bullet_active = 1'($urandom_range(0, 1));
            load(4'($urandom_range(0, 9)), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(5, 120)) begin
                @(negedge clk);
                enable_draw = ($urandom_range(0, 9) < 8);
                enable_load = ($urandom_range(0, 99) < 2);
                if (enable_load) draw_select = 4'($urandom_range(0, 7));
            end
            @(negedge clk);
            enable_load = 1'b0;
        end

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
